// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: branch-type codes and 2-bit counter encodings shared by the predictor.
package branch_predictor_pkg;
  localparam logic [2:0] NOBRANCH = 3'd0;
  localparam logic [2:0] BEQ      = 3'd1;
  localparam logic [2:0] BNE      = 3'd2;
  localparam logic [2:0] BLT      = 3'd3;
  localparam logic [2:0] BGE      = 3'd4;
  localparam logic [2:0] BLTU     = 3'd5;
  localparam logic [2:0] BGEU     = 3'd6;
  localparam logic [1:0] CTR_SNT  = 2'b00;
  localparam logic [1:0] CTR_WNT  = 2'b01;
  localparam logic [1:0] CTR_WT   = 2'b10;
  localparam logic [1:0] CTR_ST   = 2'b11;
endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: combinational next state of a 2-bit saturating taken/not-taken counter.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] next
);
  always_comb
    next = taken ? ((ctr == CTR_ST) ? ctr : ctr + 2'd1)
                 : ((ctr == CTR_SNT) ? ctr : ctr - 2'd1);
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters, combinational lookup and EX resolve.
// Defining BP_STATS_EN adds resolve/mispredict counters BrCountE and MissCountE.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  input  logic        UpdateEnE,
`ifdef BP_STATS_EN
  output logic [31:0] BrCountE,
  output logic [31:0] MissCountE,
`endif
  output logic        MispredictE,
  output logic [31:0] CorrectPCE
);
  localparam int N = 1 << IDX_W;
  logic             valid_q [N];
  logic [TAG_W-1:0] tag_q   [N];
  logic [31:0]      tgt_q   [N];
  logic [1:0]       ctr_q   [N];
  logic [IDX_W-1:0] fidx, eidx;
  logic [TAG_W-1:0] ftag, etag;
  logic             fhit, ehit, resolve;
  logic [1:0]       ctr_nx;
  assign fidx = PCF[IDX_W+1:2];
  assign ftag = PCF[31:IDX_W+2];
  assign eidx = PCE[IDX_W+1:2];
  assign etag = PCE[31:IDX_W+2];
  always_comb begin
    fhit        = valid_q[fidx] && (tag_q[fidx] == ftag);
    PredTakenF  = fhit && ctr_q[fidx][1];
    PredTargetF = PredTakenF ? tgt_q[fidx] : PCF + 32'd4;
    ehit        = valid_q[eidx] && (tag_q[eidx] == etag);
    resolve     = UpdateEnE && (BranchTypeE != NOBRANCH);
    MispredictE = resolve && ((PredTakenE != BranchE) ||
                  (PredTakenE && BranchE && (PredTargetE != BranchTargetE)));
    CorrectPCE  = (MispredictE && BranchE) ? BranchTargetE : PCE + 32'd4;
  end
  sat_counter2 u_ctr (.ctr(ctr_q[eidx]), .taken(BranchE), .next(ctr_nx));
  // Tags and targets need no reset: a cleared valid bit hides them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (resolve) begin
      if (ehit) begin
        ctr_q[eidx] <= ctr_nx;
        if (BranchE) tgt_q[eidx] <= BranchTargetE;
      end else if (BranchE) begin
        valid_q[eidx] <= 1'b1;
        tag_q[eidx]   <= etag;
        tgt_q[eidx]   <= BranchTargetE;
        ctr_q[eidx]   <= CTR_WT;
      end
    end
  end
`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      BrCountE   <= '0;
      MissCountE <= '0;
    end else if (resolve) begin
      BrCountE   <= BrCountE + 32'd1;
      MissCountE <= MissCountE + {31'd0, MispredictE};
    end
  end
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed self-checking bench for branch_predictor.
module tb_branch_predictor;
  import branch_predictor_pkg::*;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PCF, PredTargetF, PCE, BranchTargetE, PredTargetE, CorrectPCE;
  logic        PredTakenF, BranchE, PredTakenE, UpdateEnE, MispredictE;
  logic [2:0]  BranchTypeE;
`ifdef BP_STATS_EN
  logic [31:0] BrCountE, MissCountE;
`endif
  int cmp = 0;
  int errs = 0;
  always #5 clk = ~clk;
  branch_predictor dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .PCE(PCE), .BranchTypeE(BranchTypeE), .BranchE(BranchE), .BranchTargetE(BranchTargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .UpdateEnE(UpdateEnE),
`ifdef BP_STATS_EN
    .BrCountE(BrCountE), .MissCountE(MissCountE),
`endif
    .MispredictE(MispredictE), .CorrectPCE(CorrectPCE)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic res(input logic [31:0] pce, input logic [2:0] bt, input logic tk,
                     input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                     input logic en);
    PCE = pce; BranchTypeE = bt; BranchE = tk; BranchTargetE = tgt;
    PredTakenE = ptk; PredTargetE = ptgt; UpdateEnE = en;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    UpdateEnE = 1'b0;
    BranchTypeE = NOBRANCH;
    #1;
  endtask
  task automatic look(input string tag, input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    PCF = pc;
    #1;
    chk({tag, "_taken"}, {31'd0, PredTakenF}, {31'd0, tk});
    chk({tag, "_target"}, PredTargetF, tgt);
  endtask
  initial begin
    rst = 1'b1; PCF = 0;
    res(0, NOBRANCH, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    look("reset_lookup", 32'h100, 0, 32'h104);
    res(32'h100, BEQ, 1, 32'h80, 0, 32'h104, 1);
    chk("alloc_mispredict", {31'd0, MispredictE}, 1);
    chk("alloc_correctpc", CorrectPCE, 32'h80);
    look("same_cycle_old", 32'h100, 0, 32'h104);
    tick();
    look("after_alloc", 32'h100, 1, 32'h80);
    res(32'h100, BEQ, 0, 32'h80, 1, 32'h80, 1);
    chk("nt1_mispredict", {31'd0, MispredictE}, 1);
    chk("nt1_correctpc", CorrectPCE, 32'h104);
    tick();
    look("ctr_wnt", 32'h100, 0, 32'h104);
    res(32'h100, BEQ, 0, 32'h80, 0, 32'h104, 1);
    chk("nt2_correct", {31'd0, MispredictE}, 0);
    tick();
    res(32'h100, BEQ, 1, 32'h80, 0, 32'h104, 1);
    chk("t_from_snt_mispredict", {31'd0, MispredictE}, 1);
    tick();
    look("ctr_snt_to_wnt", 32'h100, 0, 32'h104);
    res(32'h100, BEQ, 1, 32'h80, 0, 32'h104, 1);
    tick();
    look("ctr_wt", 32'h100, 1, 32'h80);
    res(32'h100, BNE, 1, 32'h200, 1, 32'h80, 1);
    chk("tgt_change_mispredict", {31'd0, MispredictE}, 1);
    chk("tgt_change_correctpc", CorrectPCE, 32'h200);
    tick();
    look("tgt_updated", 32'h100, 1, 32'h200);
    res(32'h100, BNE, 1, 32'h200, 1, 32'h200, 1);
    chk("correct_taken", {31'd0, MispredictE}, 0);
    tick();
    res(32'h100, BNE, 0, 32'h200, 1, 32'h200, 1);
    tick();
    look("ctr_st_to_wt", 32'h100, 1, 32'h200);
    res(32'h200, BLT, 1, 32'h300, 0, 32'h204, 1);
    tick();
    look("alias_evicted", 32'h100, 0, 32'h104);
    look("alias_new", 32'h200, 1, 32'h300);
    res(32'h40, BNE, 1, 32'h500, 0, 32'h44, 0);
    chk("noupd_mispredict", {31'd0, MispredictE}, 0);
    chk("noupd_correctpc", CorrectPCE, 32'h44);
    tick();
    look("noupd_table", 32'h40, 0, 32'h44);
    res(32'h40, NOBRANCH, 1, 32'h500, 0, 32'h44, 1);
    chk("nobranch_mispredict", {31'd0, MispredictE}, 0);
    tick();
    look("nobranch_table", 32'h40, 0, 32'h44);
    res(32'h40, BGEU, 1, 32'h600, 0, 32'h44, 1);
    tick();
    look("pre_reset", 32'h40, 1, 32'h600);
    rst = 1'b1;
    res(32'h80, BEQ, 1, 32'h700, 0, 32'h84, 1);
    tick();
    rst = 1'b0;
    look("rst_miss_40", 32'h40, 0, 32'h44);
    look("rst_miss_200", 32'h200, 0, 32'h204);
    look("rst_discard_80", 32'h80, 0, 32'h84);
`ifdef BP_STATS_EN
    chk("rst_brcount", BrCountE, 0);
    chk("rst_misscount", MissCountE, 0);
    res(32'h80, BEQ, 1, 32'h700, 0, 32'h84, 1);
    tick();
    res(32'h80, BEQ, 1, 32'h700, 1, 32'h700, 1);
    tick();
    chk("brcount", BrCountE, 2);
    chk("misscount", MissCountE, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the 5-stage RISC-V pipeline. Looks up the fetch PC each cycle in a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, and supplies a predicted next PC to IF. Consumes the EX-stage branch outcome produced by branch decision logic (`BranchE`, `BranchTypeE`). It updates the table and flags mispredictions so the hazard unit can flush IF/ID and redirect fetch.

## Interface
Parameters:
- `IDX_W`, 6: index width; table holds 2^IDX_W entries.
- `TAG_W`, 30-IDX_W: tag width, equal to PC[31:IDX_W+2].

Ports:
- `clk` input 1: sole clock, all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `PCF` input 32: fetch PC.
- `PredTakenF` output 1: predicted taken for `PCF`.
- `PredTargetF` output 32: predicted target; equals PCF+4 when `PredTakenF`=0.
- `PCE` input 32: PC of the instruction in EX.
- `BranchTypeE` input 3: branch type; `NOBRANCH` marks a non-branch.
- `BranchE` input 1: actual outcome from branch decision logic.
- `BranchTargetE` input 32: computed taken target.
- `PredTakenE` input 1: `PredTakenF` piped to EX with the instruction.
- `PredTargetE` input 32: `PredTargetF` piped to EX.
- `UpdateEnE` input 1: 0 while EX is stalled or flushed; blocks table update and mispredict.
- `MispredictE` output 1: prediction wrong; flush IF/ID and redirect.
- `CorrectPCE` output 32: PC to fetch on mispredict.

## Operation
- Index is `PC[IDX_W+1:2]`. Tag is `PC[31:IDX_W+2]`. Each entry holds `valid`, `tag`, `target[31:0]` and `ctr[1:0]`.
- Counter encoding:
  - 00 strong NT
  - 01 weak NT
  - 10 weak T
  - 11 strong T
- Lookup is combinational on `PCF`. Hit means valid and tag match. `PredTakenF` = hit & ctr[1]. `PredTargetF` = entry target if `PredTakenF`, else PCF+4.
- Resolve occurs only when `UpdateEnE`=1 and `BranchTypeE`≠`NOBRANCH`:
  - `PredTakenE`=1, `BranchE`=0: mispredict; `CorrectPCE` = PCE+4.
  - `PredTakenE`=0, `BranchE`=1: mispredict; `CorrectPCE` = `BranchTargetE`.
  - `PredTakenE`=1, `BranchE`=1, `PredTargetE`≠`BranchTargetE`: mispredict; `CorrectPCE` = `BranchTargetE`.
  - Otherwise no mispredict.
- When not resolving, `MispredictE`=0 and `CorrectPCE`=PCE+4.
- Table update, applied on the next edge, only when resolving:
  - Hit: ctr saturates +1 if taken, −1 if not taken. Target is overwritten with `BranchTargetE` when taken.
  - Miss and taken: allocate the entry (overwrites any occupant). Set valid=1, tag, target, ctr=10.
  - Miss and not taken: no change.
- Jumps (JAL/JALR) are outside this block and are never entered into the table.

## Timing
- Lookup has zero latency: combinational, same cycle as `PCF`.
- `MispredictE`/`CorrectPCE` are combinational from EX inputs, valid in the same cycle as `BranchE`.
- A table write at edge N is visible to lookups from cycle N+1. Same-cycle lookup at the index being written returns the old contents.
- Reset: on an edge with `rst`=1, every valid bit clears and every ctr becomes 01.
  - `PredTakenF`=0 and `PredTargetF`=PCF+4 from the following cycle.
  - The update of that edge is discarded.
  - `rst` asserted mid-operation behaves identically.
- Table storage is flip-flops, not block RAM, so the reset clear takes one cycle.

## Configuration
- `BP_STATS_EN` defined adds outputs `BrCountE[31:0]` and `MissCountE[31:0]`, both reset to 0 by `rst`.
  - `BrCountE` increments on every resolve.
  - `MissCountE` increments on every resolve with `MispredictE`=1.
  - Both counters wrap modulo 2^32.
- Without `BP_STATS_EN`, these ports and registers do not exist.

## Structure
- Shared parameters file: branch-type codes (`NOBRANCH`, `BEQ`, …) already defined there, plus counter encodings `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST`.
- One sub-module: `sat_counter2`, a combinational 2-bit saturating next-state function (inputs ctr and taken), instantiated once on the update path.

## Test plan
- Reset, then `PCF`=0x100 → `PredTakenF`=0, `PredTargetF`=0x104.
- Resolve BEQ at `PCE`=0x100, taken, target 0x80, `PredTakenE`=0 → `MispredictE`=1, `CorrectPCE`=0x80. Next cycle `PCF`=0x100 gives `PredTakenF`=1, `PredTargetF`=0x80.
- Same branch resolved not-taken twice with `PredTakenE`=1 → first resolve: mispredict, `CorrectPCE`=0x104, ctr 10→01. Second resolve: ctr 01→00, `PCF`=0x100 then predicts not taken.
- Alias: allocate 0x100, then taken branch at 0x100+(4<<IDX_W) → entry replaced. `PCF`=0x100 misses, predicts 0x104.
- `UpdateEnE`=0 with `BranchE`=1, `PredTakenE`=0 → `MispredictE`=0, table unchanged.
- `rst` asserted one cycle after allocation → all lookups miss. With `BP_STATS_EN`, both counters read 0.
